fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output reorder buffer at the tail of the pipeline FFT: the write-side counterpart of the stage buffer that feeds butterfly pairs. It accepts butterfly result pairs (two complex samples per strobe), stores each sample at its bit-reversed address in one of two banks, and streams completed frames out one complex sample per clock in natural bin order. Ping-pong banking lets frame k be read while frame k+1 is written.

## Interface
- bit_width, 29, width of each signed real/imag sample
- N, 16, frame length in samples (power of two, ≥4)
- SIZE, 4, log2(N), address width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en_add  in  1  pair valid strobe from last butterfly stage
- Re_i1, Im_i1  in  bit_width  first sample of pair (signed)
- Re_i2, Im_i2  in  bit_width  second sample of pair (signed)
- Re_o, Im_o  out  bit_width  output sample (signed, registered)
- en_o  out  1  output sample valid
- idx_o  out  SIZE  natural-order bin index of current output
- frame_start  out  1  high with bin 0 of each frame
- overflow  out  1  sticky: a pair was dropped

## Operation
- Pair counter pc (SIZE-1 bits) counts accepted pairs of the current write frame; pair j carries stream positions p=2j (sample 1) and p=2j+1 (sample 2).
- Sample at position p is written to address bitrev(p) (SIZE-bit reversal) of write bank wb; both samples are written in the same cycle (two write ports).
- Pair accepted when en_add=1 and full[wb]=0. On acceptance of pair N/2-1: full[wb]<=1, wb toggles, pc<=0.
- en_add=1 with full[wb]=1: pair dropped, pc unchanged, overflow<=1 (held until reset).
- Read FSM, states IDLE and READ:
  - IDLE: if full[rb], go READ, rd_addr<=0.
  - READ: each cycle register mem[rb][rd_addr] onto Re_o/Im_o, idx_o<=rd_addr, en_o<=1, frame_start<=(rd_addr==0); rd_addr++.
  - On reading address N-1: full[rb]<=0, rb toggles, rd_addr<=0; if the other bank is already full, stay in READ (no gap), else go IDLE.
- Read-before-write: a write and a read to the same bank address in one cycle returns the old value.
- Accept-and-release same cycle: pair for bank b arriving on the cycle bank b's last address is read is dropped (full[b] still 1 at sampling); only the next cycle sees the bank free.
- No arithmetic; samples are passed bit-exact, no width change.

## Timing
- Reset (rst_n=0 at a rising edge): en_o=0, frame_start=0, overflow=0, Re_o=Im_o=0, idx_o=0, full=00, wb=rb=0, pc=0, FSM IDLE. Partial frame discarded; memory contents not cleared.
- Latency: edge E0 accepts final pair of a frame; E1 FSM leaves IDLE; en_o first high after E1 with idx_o=0 (2 edges after E0 when reader was idle).
- Output burst: exactly N consecutive en_o cycles per frame, idx_o 0..N-1.
- Sustained throughput: one pair per 2 cycles never overflows; one pair per cycle overflows after the second bank fills.
- Outputs change only on rising edges; en_o low in IDLE, Re_o/Im_o hold last value.

## Structure
- Package fft_pkg: bitrev function (SIZE-parameterised), FSM state localparams IDLE/READ.
- Single module; no sub-module needed. Memory as two reg arrays per component (Re, Im) per bank.

## Test plan
- N=16, 8 pairs, sample at position p = (Re=p, Im=-p), one pair every 2 cycles -> 16 outputs, idx_o=k carries Re=bitrev(k) (k=1 -> Re=8, k=3 -> Re=12), frame_start only at k=0, first en_o 2 edges after 8th pair.
- Two frames back-to-back at one pair per 2 cycles -> 32 contiguous en_o cycles, no gap, overflow=0.
- Pairs every cycle for 3 frames with no reader gap -> first two frames correct, overflow=1, at least one pair dropped from frame 3, no corruption of frames 1-2.
- Reset asserted after 5 pairs -> all outputs 0 next cycle; fresh full frame afterwards reads out correctly from bin 0.
- Both banks full, pair arrives on cycle bank 0's address 15 is read -> pair dropped, overflow=1; pair one cycle later accepted into bank 0.
- Extreme values Re=-2^28, Im=2^28-1 -> passed through bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: read FSM state codes
// and the bit-reversal helper used to scatter samples into natural bin order.
package fft_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic READ = 1'b1;

  // Reverses the low `size` bits of v; bits above `size` come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int size);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = v;
    for (int i = 0; i < 32; i++) begin
      if (i < size) begin
        r = {r[30:0], s[0]};
        s = {1'b0, s[31:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer at the FFT tail: pairs are scattered to bit-reversed
// addresses of the write bank, full banks stream out one sample per clock in bin order.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_add,
  input  logic [bit_width-1:0] Re_i1,
  input  logic [bit_width-1:0] Im_i1,
  input  logic [bit_width-1:0] Re_i2,
  input  logic [bit_width-1:0] Im_i2,
  output logic [bit_width-1:0] Re_o,
  output logic [bit_width-1:0] Im_o,
  output logic                 en_o,
  output logic [SIZE-1:0]      idx_o,
  output logic                 frame_start,
  output logic                 overflow
);

  // en_add is a valid-only strobe with no ready: a pair is taken when the
  // write bank is free, otherwise it is lost and overflow latches.

  logic                 state_q, state_d;
  logic [SIZE-1:0]      rd_addr_q, rd_addr_d;
  logic                 rb_q, rb_d;
  logic                 wb_q, wb_d;
  logic [SIZE-2:0]      pc_q, pc_d;
  logic [1:0]           full_q, full_d;
  logic                 overflow_q, overflow_d;
  logic [bit_width-1:0] re_q, re_d;
  logic [bit_width-1:0] im_q, im_d;
  logic [SIZE-1:0]      idx_q, idx_d;
  logic                 en_q, en_d;
  logic                 fs_q, fs_d;

  logic [bit_width-1:0] mem_re0_q [0:N-1];
  logic [bit_width-1:0] mem_im0_q [0:N-1];
  logic [bit_width-1:0] mem_re1_q [0:N-1];
  logic [bit_width-1:0] mem_im1_q [0:N-1];

  logic            accept;
  logic            pc_last;
  logic            rd_last;
  logic [SIZE-1:0] wa1;
  logic [SIZE-1:0] wa2;

  always_comb begin
    accept  = en_add && !full_q[wb_q];
    pc_last = (pc_q == (SIZE-1)'(N/2 - 1));
    rd_last = (state_q == READ) && (rd_addr_q == SIZE'(N - 1));
    wa1     = SIZE'(bitrev(32'({pc_q, 1'b0}), SIZE));
    wa2     = SIZE'(bitrev(32'({pc_q, 1'b1}), SIZE));
  end

  // Write side: pair counter, bank select, full flags and sticky overflow.
  // A bank released this cycle still reads as full to an arriving pair.
  always_comb begin
    wb_d       = wb_q;
    pc_d       = pc_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    if (en_add) begin
      if (full_q[wb_q]) begin
        overflow_d = 1'b1;
      end else if (pc_last) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        pc_d         = '0;
      end else begin
        pc_d = pc_q + (SIZE-1)'(1);
      end
    end
    if (rd_last) begin
      full_d[rb_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      if (wb_q) begin
        mem_re1_q[wa1] <= Re_i1;
        mem_im1_q[wa1] <= Im_i1;
        mem_re1_q[wa2] <= Re_i2;
        mem_im1_q[wa2] <= Im_i2;
      end else begin
        mem_re0_q[wa1] <= Re_i1;
        mem_im0_q[wa1] <= Im_i1;
        mem_re0_q[wa2] <= Re_i2;
        mem_im0_q[wa2] <= Im_i2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rb_q       <= 1'b0;
      wb_q       <= 1'b0;
      pc_q       <= '0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
      idx_q      <= '0;
      en_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rb_q       <= rb_d;
      wb_q       <= wb_d;
      pc_q       <= pc_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      re_q       <= re_d;
      im_q       <= im_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      fs_q       <= fs_d;
    end
  end

  // Staying in READ when the other bank is already full keeps frames gap-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_q[rb_q]) state_d = READ;
      READ:    if (rd_last && !full_q[~rb_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    rb_d      = rb_q;
    en_d      = 1'b0;
    fs_d      = 1'b0;
    re_d      = re_q;
    im_d      = im_q;
    idx_d     = idx_q;
    if (state_q == IDLE) begin
      if (full_q[rb_q]) rd_addr_d = '0;
    end else begin
      re_d      = rb_q ? mem_re1_q[rd_addr_q] : mem_re0_q[rd_addr_q];
      im_d      = rb_q ? mem_im1_q[rd_addr_q] : mem_im0_q[rd_addr_q];
      idx_d     = rd_addr_q;
      en_d      = 1'b1;
      fs_d      = (rd_addr_q == '0);
      rd_addr_d = rd_addr_q + SIZE'(1);
      if (rd_last) rb_d = ~rb_q;
    end
  end

  assign Re_o        = re_q;
  assign Im_o        = im_q;
  assign idx_o       = idx_q;
  assign en_o        = en_q;
  assign frame_start = fs_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: directed scenarios with random data,
// checked against a frame-level timing/occupancy model of the reorder buffer.
module tb_fft_out_reorder;

  localparam int BW = 29;
  localparam int N  = 16;
  localparam int SZ = 4;
  localparam int W  = 1 + SZ + 2 * BW;
  localparam logic [BW-1:0] MIN_V = {1'b1, {(BW-1){1'b0}}};
  localparam logic [BW-1:0] MAX_V = {1'b0, {(BW-1){1'b1}}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_add = 1'b0;
  logic [BW-1:0] re_i1 = '0, im_i1 = '0, re_i2 = '0, im_i2 = '0;
  logic [BW-1:0] re_o, im_o;
  logic          en_o;
  logic [SZ-1:0] idx_o;
  logic          frame_start;
  logic          overflow;

  fft_out_reorder #(.bit_width(BW), .N(N), .SIZE(SZ)) dut (
    .clk(clk), .rst_n(rst_n), .en_add(en_add),
    .Re_i1(re_i1), .Im_i1(im_i1), .Re_i2(re_i2), .Im_i2(im_i2),
    .Re_o(re_o), .Im_o(im_o), .en_o(en_o), .idx_o(idx_o),
    .frame_start(frame_start), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  int            total = 0;
  int            bad = 0;
  bit            mon_on = 1'b0;
  int            frame_no;
  int            pc_m;
  int            rel [0:63];
  logic [BW-1:0] fr_re [0:N-1];
  logic [BW-1:0] fr_im [0:N-1];
  bit            ov_m;
  logic [W-1:0]  exp_q[$];
  int            exp_t[$];
  logic [BW-1:0] last_re, last_im;
  logic [SZ-1:0] last_idx;
  int            run_len, max_run;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
    end
  endtask

  function automatic int rev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < SZ; b++)
      if ((k & (1 << b)) != 0) r = r | (1 << (SZ - 1 - b));
    return r;
  endfunction

  task automatic model_reset();
    frame_no = 0;
    pc_m     = 0;
    ov_m     = 1'b0;
    exp_q.delete();
    exp_t.delete();
    last_re  = '0;
    last_im  = '0;
    last_idx = '0;
  endtask

  // Frame f lives in bank f%2; a frame is read starting the edge after it
  // completes, or right behind the previous frame, and frees its bank on the
  // edge its last bin is read.
  task automatic model_complete(input int t);
    int s;
    s = t + 1;
    if (frame_no > 0 && rel[frame_no-1] > s) s = rel[frame_no-1];
    rel[frame_no] = s + N;
    for (int k = 0; k < N; k++) begin
      exp_t.push_back(s + 1 + k);
      exp_q.push_back({(k == 0), SZ'(k), fr_re[rev(k)], fr_im[rev(k)]});
    end
    frame_no++;
    pc_m = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [BW-1:0] r1, input logic [BW-1:0] i1,
                            input logic [BW-1:0] r2, input logic [BW-1:0] i2);
    int t;
    en_add = 1'b1;
    re_i1 = r1; im_i1 = i1; re_i2 = r2; im_i2 = i2;
    @(posedge clk);
    #1;
    en_add = 1'b0;
    t = cyc;
    if (frame_no >= 2 && rel[frame_no-2] >= t) begin
      ov_m = 1'b1;
    end else begin
      fr_re[2*pc_m]   = r1;
      fr_im[2*pc_m]   = i1;
      fr_re[2*pc_m+1] = r2;
      fr_im[2*pc_m+1] = i2;
      pc_m++;
      if (pc_m == N/2) model_complete(t);
    end
  endtask

  task automatic drive_rand();
    drive_pair(BW'($urandom()), BW'($urandom()), BW'($urandom()), BW'($urandom()));
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en_add = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    mon_on = 1'b1;
    rst_n  = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_t.size() == 0) break;
      idle_cycle();
    end
    check(tag, 64'(exp_t.size()), 64'd0);
    idle_cycle();
    idle_cycle();
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      logic [W-1:0] e;
      logic         ee;
      logic         fs_e;
      ee   = 1'b0;
      fs_e = 1'b0;
      if (exp_t.size() > 0 && exp_t[0] == cyc) begin
        e = exp_q.pop_front();
        void'(exp_t.pop_front());
        ee       = 1'b1;
        fs_e     = e[W-1];
        last_idx = e[W-2 -: SZ];
        last_re  = e[2*BW-1 -: BW];
        last_im  = e[BW-1:0];
      end
      check("en_o", 64'(en_o), 64'(ee));
      check("frame_start", 64'(frame_start), 64'(fs_e));
      check("idx_o", 64'(idx_o), 64'(last_idx));
      check("re_o", 64'(re_o), 64'(last_re));
      check("im_o", 64'(im_o), 64'(last_im));
      check("overflow", 64'(overflow), 64'(ov_m));
      if (en_o === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [BW-1:0] neg8;
    logic [BW-1:0] neg12;
    int guard;
    model_reset();
    run_len = 0;
    max_run = 0;
    neg8  = BW'(-8);
    neg12 = BW'(-12);

    do_reset();
    do_reset();
    check("reset_en_o", 64'(en_o), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);

    // Ramp frame: sample p carries (p, -p), one pair every 2 cycles.
    for (int j = 0; j < N/2; j++) begin
      drive_pair(BW'(2*j), BW'(-(2*j)), BW'(2*j+1), BW'(-(2*j+1)));
      if (j != N/2 - 1) idle_cycle();
    end
    check("lat_e0_en", 64'(en_o), 64'd0);
    idle_cycle();
    check("lat_e1_en", 64'(en_o), 64'd0);
    idle_cycle();
    check("lat_e2_en", 64'(en_o), 64'd1);
    check("bin0_idx", 64'(idx_o), 64'd0);
    check("bin0_fs", 64'(frame_start), 64'd1);
    check("bin0_re", 64'(re_o), 64'd0);
    idle_cycle();
    check("bin1_idx", 64'(idx_o), 64'd1);
    check("bin1_re", 64'(re_o), 64'd8);
    check("bin1_im", 64'(im_o), 64'(neg8));
    check("bin1_fs", 64'(frame_start), 64'd0);
    idle_cycle();
    idle_cycle();
    check("bin3_re", 64'(re_o), 64'd12);
    check("bin3_im", 64'(im_o), 64'(neg12));
    drain("drain_ramp");

    // Two frames at one pair per 2 cycles: one unbroken 32-sample burst.
    max_run = 0;
    for (int j = 0; j < N; j++) begin
      drive_rand();
      idle_cycle();
    end
    drain("drain_b2b");
    check("b2b_burst_len", 64'(max_run), 64'(2*N));
    check("b2b_overflow", 64'(overflow), 64'd0);

    // Pairs every cycle: third frame collides with both full banks.
    for (int j = 0; j < 3*N/2 + 4; j++) drive_rand();
    drain("drain_flood");
    check("flood_overflow", 64'(overflow), 64'd1);

    // Reset mid-frame discards the partial frame and clears overflow.
    for (int j = 0; j < 5; j++) begin
      drive_rand();
      idle_cycle();
    end
    do_reset();
    check("midreset_en", 64'(en_o), 64'd0);
    check("midreset_re", 64'(re_o), 64'd0);
    check("midreset_idx", 64'(idx_o), 64'd0);
    check("midreset_ov", 64'(overflow), 64'd0);
    for (int j = 0; j < N/2; j++) begin
      drive_rand();
      idle_cycle();
    end
    drain("drain_after_reset");

    // Pair landing on the edge bank 0 releases is dropped; next one is taken.
    do_reset();
    for (int j = 0; j < N; j++) drive_rand();
    check("both_full_no_ov", 64'(overflow), 64'd0);
    guard = 0;
    while (cyc < rel[0] - 1 && guard < 100) begin
      idle_cycle();
      guard++;
    end
    check("release_wait", 64'(guard < 100), 64'd1);
    drive_rand();
    check("release_edge_drop", 64'(overflow), 64'd1);
    for (int j = 0; j < N/2; j++) drive_rand();
    drain("drain_release");

    // Extreme values pass through bit-exact.
    for (int j = 0; j < N/2; j++) begin
      drive_pair(MIN_V, MAX_V, MAX_V, MIN_V);
      idle_cycle();
    end
    drain("drain_extreme");
    check("extreme_last_im", 64'(im_o), 64'(MIN_V));

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
